alu_share_ctrl: RTL

Round-robin arbiter and sequencer that shares one combinational ALU between two requesters, e.g. the execute stage and a multicycle/address-generation helper. It grants one request at a time, registers the operands and function code onto the ALU inputs, captures the ALU result one cycle later, and returns it through a valid/ready response port tagged with the requester ID. It also flags function codes the ALU does not implement.

---
 rtl/alu_share_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters.
// A round-robin arbiter grants one request at a time. The granted operands are
// registered onto the ALU inputs, the result is captured one cycle later, and
// it is returned on a valid/ready response port tagged with the requester ID.
// Function codes the ALU does not implement are flagged on rsp_err.
// Only WIDTH = 32 is meaningful because the attached ALU is 32-bit.

module alu_share_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    // Requester 0
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_srcA,
    input  logic [WIDTH-1:0] r0_srcB,
    input  logic [3:0]       r0_fun,

    // Requester 1
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_srcA,
    input  logic [WIDTH-1:0] r1_srcB,
    input  logic [3:0]       r1_fun,

    // Shared ALU
    output logic [WIDTH-1:0] alu_srcA,
    output logic [WIDTH-1:0] alu_srcB,
    output logic [3:0]       alu_fun,
    input  logic [WIDTH-1:0] alu_result,

    // Response port
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    // ALU function encodings the shared ALU implements.
    localparam logic [3:0] FunAdd  = 4'b0000;
    localparam logic [3:0] FunSub  = 4'b1000;
    localparam logic [3:0] FunOr   = 4'b0110;
    localparam logic [3:0] FunAnd  = 4'b0111;
    localparam logic [3:0] FunXor  = 4'b0100;
    localparam logic [3:0] FunSrl  = 4'b0101;
    localparam logic [3:0] FunSll  = 4'b0001;
    localparam logic [3:0] FunSra  = 4'b1101;
    localparam logic [3:0] FunSlt  = 4'b0010;
    localparam logic [3:0] FunSltu = 4'b0011;
    localparam logic [3:0] FunLui  = 4'b1001;

    // True when the code is one the ALU implements.
    function automatic logic fun_legal(input logic [3:0] fun);
        logic legal;
        case (fun)
            FunAdd, FunSub, FunOr, FunAnd, FunXor, FunSrl,
            FunSll, FunSra, FunSlt, FunSltu, FunLui: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_e           state_q;
    logic             last_grant_q;  // ID of the most recent grant; 1 so r0 wins first tie
    logic             pend_id_q;     // ID of the operation currently in the ALU
    logic [WIDTH-1:0] alu_srcA_q;
    logic [WIDTH-1:0] alu_srcB_q;
    logic [3:0]       alu_fun_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_err_q;

    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic             hs;
    logic             hs_id;
    logic [WIDTH-1:0] sel_srcA;
    logic [WIDTH-1:0] sel_srcB;
    logic [3:0]       sel_fun;

    // Round-robin arbitration: a lone requester wins, a tie goes to the one
    // not granted last.
    always_comb begin
        gnt0 = r0_valid && (!r1_valid || last_grant_q);
        gnt1 = r1_valid && (!r0_valid || !last_grant_q);
    end

    // Grants are only offered in IDLE; rst_n gates them so both readys read 0
    // while reset is held, independent of requester valids.
    always_comb begin
        accept   = rst_n && (state_q == StIdle);
        r0_ready = accept && gnt0;
        r1_ready = accept && gnt1;
        hs       = r0_ready || r1_ready;
        hs_id    = r1_ready;
        sel_srcA = r1_ready ? r1_srcA : r0_srcA;
        sel_srcB = r1_ready ? r1_srcB : r0_srcB;
        sel_fun  = r1_ready ? r1_fun  : r0_fun;
    end

    // Sequencer: IDLE grants and latches operands, EXEC captures the ALU
    // result, RESP holds the response until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            pend_id_q    <= 1'b0;
            alu_srcA_q   <= '0;
            alu_srcB_q   <= '0;
            alu_fun_q    <= 4'b0000;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (hs) begin
                        alu_srcA_q   <= sel_srcA;
                        alu_srcB_q   <= sel_srcB;
                        alu_fun_q    <= sel_fun;
                        pend_id_q    <= hs_id;
                        last_grant_q <= hs_id;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    // Illegal codes return 32'hDEADBEEF from the ALU; forward it
                    // untouched and just raise the error flag.
                    rsp_result_q <= alu_result;
                    rsp_id_q     <= pend_id_q;
                    rsp_err_q    <= !fun_legal(alu_fun_q);
                    rsp_valid_q  <= 1'b1;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    // Drive registered outputs.
    always_comb begin
        alu_srcA   = alu_srcA_q;
        alu_srcB   = alu_srcB_q;
        alu_fun    = alu_fun_q;
        rsp_valid  = rsp_valid_q;
        rsp_id     = rsp_id_q;
        rsp_result = rsp_result_q;
        rsp_err    = rsp_err_q;
    end

endmodule
